alu_issue_ctrl: RTL and testbench

//  Instruction-side initiator for the 16-bit SIMD lane ALU.
//  - Accepts 16-bit instruction words over a valid/ready handshake.
//  - Decodes each word and reads operands from an internal 8x16 register file.
//  - Drives the ALU one-hot enables and operands, samples the combinational ALU result and writes it back.

---
 rtl/alu_issue_pkg.sv | 37 +++
 rtl/alu_issue_regfile.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared definitions for the SIMD-lane ALU issue controller:
//   opcode values, instruction field positions, the 2-bit FSM state
//   encoding and the ALU enable group.
//   Instruction word layout:
//     [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [8:0] imm (LDI only)
package alu_issue_pkg;

    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_BITREV = 4'h3;
    localparam logic [3:0] OP_MUL    = 4'h4;
    localparam logic [3:0] OP_LDI    = 4'h5;

    localparam int INSTR_W = 16;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // ALU enable group; at most one member is ever set
    typedef struct packed {
        logic mul;
        logic bitrev;
        logic sub;
        logic add;
    } alu_en_t;

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile
//   NREGS x DATA_W register file for the ALU issue controller.
//   Ports:
//     clk, rst             clock, asynchronous active-low clear
//     rd1_addr/rd1_data    combinational read port (rs1)
//     rd2_addr/rd2_data    combinational read port (rs2)
//     dbg_addr/dbg_data    combinational debug read port
//     we/waddr/wdata       synchronous write port
module alu_issue_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [REG_AW-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [NREGS-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    mem        <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    assign rd1_data = mem[rd1_addr];
    assign rd2_data = mem[rd2_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Instruction-side initiator for the 16-bit SIMD lane ALU. Accepts one
//   instruction word per handshake, reads operands from the register file,
//   drives one ALU enable for a single cycle, captures the combinational
//   ALU result and writes it back. Non-pipelined: IDLE-DECODE-EXEC-WB
//   for ALU ops, IDLE-DECODE-WB for LDI.
//   Ports:
//     clk, rst                     clock, asynchronous active-low reset
//     instr_valid/ready/data       instruction handshake (ready only in IDLE)
//     Radd_en/Rsub_en/bitrev_en/mul_en  registered one-hot ALU enables
//     rs1_data, rs2_data           registered ALU operands (0 outside EXEC)
//     aluresult_in                 combinational ALU result
//     wb_valid/wb_addr/wb_data     write-back pulse and its address/value
//     illegal_op                   pulse for a dropped undefined opcode
//     dbg_addr/dbg_data            combinational register file peek
//   Optional: define ALU_ISSUE_FLAGS_EN to add zero_flag/neg_flag, updated
//   on ALU-op write-back from the written value.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr_data,
    output logic               Radd_en,
    output logic               Rsub_en,
    output logic               bitrev_en,
    output logic               mul_en,
    output logic [DATA_W-1:0]  rs1_data,
    output logic [DATA_W-1:0]  rs2_data,
    input  logic [DATA_W-1:0]  aluresult_in,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               illegal_op,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
   ,output logic               zero_flag,
    output logic               neg_flag
`endif
);

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    alu_en_t              en_q, en_d;
    logic [DATA_W-1:0]    rs1_d, rs2_d, res_q, res_d, wb_data_d;
    logic [DATA_W-1:0]    rd1_data, rd2_data;
    logic                 wb_valid_d, illegal_d, we;
    logic [REG_AW-1:0]    wb_addr_d;

    logic [3:0]           op;
    logic [REG_AW-1:0]    rd, rs1, rs2;

    assign op  = instr_q[OP_LSB  +: 4];
    assign rd  = instr_q[RD_LSB  +: REG_AW];
    assign rs1 = instr_q[RS1_LSB +: REG_AW];
    assign rs2 = instr_q[RS2_LSB +: REG_AW];

    alu_issue_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd1_addr (rs1),
        .rd1_data (rd1_data),
        .rd2_addr (rs2),
        .rd2_data (rd2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (we),
        .waddr    (rd),
        .wdata    (res_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            en_q       <= '0;
            rs1_data   <= '0;
            rs2_data   <= '0;
            res_q      <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            en_q       <= en_d;
            rs1_data   <= rs1_d;
            rs2_data   <= rs2_d;
            res_q      <= res_d;
            wb_valid   <= wb_valid_d;
            wb_addr    <= wb_addr_d;
            wb_data    <= wb_data_d;
            illegal_op <= illegal_d;
        end
    end

    // Operands are read here in DECODE, so rd==rs1/rs2 sees the old value.
    // wb_valid is registered off the WB-state write, so it appears together
    // with the new contents on the debug port.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        en_d       = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        res_d      = res_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr;
        wb_data_d  = wb_data;
        illegal_d  = 1'b0;
        we         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_MUL: begin
                        en_d.add = (op == OP_ADD);
                        en_d.sub = (op == OP_SUB);
                        en_d.mul = (op == OP_MUL);
                        rs1_d    = rd1_data;
                        rs2_d    = rd2_data;
                        state_d  = ST_EXEC;
                    end
                    OP_BITREV: begin
                        en_d.bitrev = 1'b1;
                        rs1_d       = rd1_data;
                        state_d     = ST_EXEC;
                    end
                    OP_LDI: begin
                        res_d   = {{(DATA_W-IMM_W){1'b0}}, instr_q[IMM_W-1:0]};
                        state_d = ST_WB;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                endcase
            end
            ST_EXEC: begin
                res_d   = aluresult_in;
                state_d = ST_WB;
            end
            ST_WB: begin
                we         = 1'b1;
                wb_valid_d = 1'b1;
                wb_addr_d  = rd;
                wb_data_d  = res_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign Radd_en     = en_q.add;
    assign Rsub_en     = en_q.sub;
    assign bitrev_en   = en_q.bitrev;
    assign mul_en      = en_q.mul;

`ifdef ALU_ISSUE_FLAGS_EN
    // Only legal opcodes reach WB, so anything but LDI there is an ALU op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
        end else if (state_q == ST_WB && op != OP_LDI) begin
            zero_flag <= (res_q == '0);
            neg_flag  <= res_q[DATA_W-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic        Radd_en, Rsub_en, bitrev_en, mul_en;
    logic [15:0] rs1_data, rs2_data;
    logic [15:0] aluresult_in;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        illegal_op;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
    logic        zero_flag, neg_flag;
`endif

    int checks   = 0;
    int failures = 0;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_data   (instr_data),
        .Radd_en      (Radd_en),
        .Rsub_en      (Rsub_en),
        .bitrev_en    (bitrev_en),
        .mul_en       (mul_en),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .aluresult_in (aluresult_in),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .illegal_op   (illegal_op),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
       ,.zero_flag    (zero_flag),
        .neg_flag     (neg_flag)
`endif
    );

    always #5 clk = ~clk;

    // Combinational ALU model attached to the controller
    logic [31:0] prod;
    assign prod = 32'(rs1_data) * 32'(rs2_data);
    always_comb begin
        aluresult_in = 16'h0000;
        if (Radd_en)        aluresult_in = rs1_data + rs2_data;
        else if (Rsub_en)   aluresult_in = rs1_data - rs2_data;
        else if (mul_en)    aluresult_in = prod[15:0];
        else if (bitrev_en) begin
            for (int i = 0; i < 16; i++) aluresult_in[i] = rs1_data[15-i];
        end
    end

    // One-hot enable monitor, active for the whole run
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (!$onehot0({mul_en, bitrev_en, Rsub_en, Radd_en})) begin
                failures++;
                $display("FAIL onehot_enables got=%b want<=1 bit", {mul_en, bitrev_en, Rsub_en, Radd_en});
            end
        end
    end

    // Stimulus helpers (no checking): issue one word, wait for write-back
    task automatic send(input logic [15:0] w);
        int k;
        for (k = 0; k < 20 && !instr_ready; k++) @(negedge clk);
        if (!instr_ready) begin
            $display("FAIL send_timeout got ready=0 want ready=1 within 20 cycles");
            $fatal(1);
        end
        instr_valid = 1'b1;
        instr_data  = w;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // n = clock edges after the accept edge until wb_valid is seen, -1 on timeout
    task automatic wait_wb(output int n);
        n = -1;
        for (int k = 0; k < 8; k++) begin
            if (wb_valid) begin
                n = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic rd_dbg(input logic [2:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        logic [15:0] any;
        @(negedge clk);
        checks++;
        if ({Radd_en, Rsub_en, bitrev_en, mul_en, wb_valid, illegal_op} !== 6'b0 ||
            rs1_data !== 16'h0 || rs2_data !== 16'h0 || wb_data !== 16'h0 || wb_addr !== 3'h0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b wbv=%b ill=%b rs1=%h rs2=%h wbd=%h want all 0",
                     {Radd_en, Rsub_en, bitrev_en, mul_en}, wb_valid, illegal_op, rs1_data, rs2_data, wb_data);
        end
        any = 16'h0;
        for (int a = 0; a < 8; a++) begin
            rd_dbg(3'(a), v);
            any |= v;
        end
        checks++;
        if (any !== 16'h0) begin
            failures++;
            $display("FAIL reset_regfile got or=%h want 0000", any);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", instr_ready);
        end
    endtask

    task automatic test_ldi_add;
        int n;
        logic [15:0] v;
        send(16'h5205);                 // LDI r1,5
        wait_wb(n);
        checks++;
        if (n !== 2 || wb_addr !== 3'd1 || wb_data !== 16'h0005) begin
            failures++;
            $display("FAIL ldi_r1 got lat=%0d addr=%0d data=%h want lat=2 addr=1 data=0005", n, wb_addr, wb_data);
        end
        send(16'h5403);                 // LDI r2,3
        wait_wb(n);
        checks++;
        if (n !== 2 || wb_addr !== 3'd2 || wb_data !== 16'h0003) begin
            failures++;
            $display("FAIL ldi_r2 got lat=%0d addr=%0d data=%h want lat=2 addr=2 data=0003", n, wb_addr, wb_data);
        end
        send(16'h1650);                 // ADD r3,r1,r2 ; now in DECODE
        checks++;
        if (Radd_en !== 1'b0 || rs1_data !== 16'h0) begin
            failures++;
            $display("FAIL add_decode got add=%b rs1=%h want add=0 rs1=0000", Radd_en, rs1_data);
        end
        @(negedge clk);                 // EXEC
        checks++;
        if ({Radd_en, Rsub_en, bitrev_en, mul_en} !== 4'b1000 || rs1_data !== 16'h0005 || rs2_data !== 16'h0003) begin
            failures++;
            $display("FAIL add_exec got en=%b rs1=%h rs2=%h want en=1000 rs1=0005 rs2=0003",
                     {Radd_en, Rsub_en, bitrev_en, mul_en}, rs1_data, rs2_data);
        end
        @(negedge clk);                 // WB
        checks++;
        if (Radd_en !== 1'b0 || rs1_data !== 16'h0 || rs2_data !== 16'h0 || wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_wb_state got add=%b rs1=%h rs2=%h wbv=%b want 0/0000/0000/0",
                     Radd_en, rs1_data, rs2_data, wb_valid);
        end
        @(negedge clk);                 // three edges after accept
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 3'd3 || wb_data !== 16'h0008) begin
            failures++;
            $display("FAIL add_wb got v=%b addr=%0d data=%h want v=1 addr=3 data=0008", wb_valid, wb_addr, wb_data);
        end
        rd_dbg(3'd3, v);
        checks++;
        if (v !== 16'h0008) begin
            failures++;
            $display("FAIL add_dbg got=%h want=0008", v);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_wb_pulse got=%b want=0", wb_valid);
        end
    endtask

    task automatic test_sub;
        int n;
        send(16'h2888);                 // SUB r4,r2,r1 = 3-5
        wait_wb(n);
        checks++;
        if (n !== 3 || wb_addr !== 3'd4 || wb_data !== 16'hFFFE) begin
            failures++;
            $display("FAIL sub_wb got lat=%0d addr=%0d data=%h want lat=3 addr=4 data=fffe", n, wb_addr, wb_data);
        end
`ifdef ALU_ISSUE_FLAGS_EN
        @(negedge clk);
        checks++;
        if (neg_flag !== 1'b1 || zero_flag !== 1'b0) begin
            failures++;
            $display("FAIL sub_flags got neg=%b zero=%b want neg=1 zero=0", neg_flag, zero_flag);
        end
`endif
        send(16'h2048);                 // SUB r0,r1,r1 = 0
        wait_wb(n);
        checks++;
        if (n !== 3 || wb_addr !== 3'd0 || wb_data !== 16'h0000) begin
            failures++;
            $display("FAIL sub_zero got lat=%0d addr=%0d data=%h want lat=3 addr=0 data=0000", n, wb_addr, wb_data);
        end
`ifdef ALU_ISSUE_FLAGS_EN
        @(negedge clk);
        checks++;
        if (neg_flag !== 1'b0 || zero_flag !== 1'b1) begin
            failures++;
            $display("FAIL sub_zero_flags got neg=%b zero=%b want neg=0 zero=1", neg_flag, zero_flag);
        end
        send(16'h5A07);                 // LDI r5,7 must leave flags alone
        wait_wb(n);
        @(negedge clk);
        checks++;
        if (neg_flag !== 1'b0 || zero_flag !== 1'b1) begin
            failures++;
            $display("FAIL ldi_flags_hold got neg=%b zero=%b want neg=0 zero=1", neg_flag, zero_flag);
        end
`endif
    endtask

    task automatic test_mul;
        int n;
        send(16'h53FF);                 // LDI r1,0x1FF
        wait_wb(n);
        checks++;
        if (wb_data !== 16'h01FF) begin
            failures++;
            $display("FAIL mul_ldi got=%h want=01ff", wb_data);
        end
        send(16'h4A48);                 // MUL r5,r1,r1
        @(negedge clk);
        checks++;
        if ({Radd_en, Rsub_en, bitrev_en, mul_en} !== 4'b0001) begin
            failures++;
            $display("FAIL mul_exec_en got=%b want=0001", {Radd_en, Rsub_en, bitrev_en, mul_en});
        end
        wait_wb(n);
        // 0x1FF * 0x1FF = 0x3FC01, low 16 bits 0xFC01
        checks++;
        if (n !== 2 || wb_addr !== 3'd5 || wb_data !== 16'hFC01) begin
            failures++;
            $display("FAIL mul_wb got lat_rem=%0d addr=%0d data=%h want lat_rem=2 addr=5 data=fc01", n, wb_addr, wb_data);
        end
    endtask

    task automatic test_bitrev;
        int n;
        send(16'h3E80);                 // BITREV r7,r2 (r2=3)
        @(negedge clk);
        checks++;
        if ({Radd_en, Rsub_en, bitrev_en, mul_en} !== 4'b0010 || rs1_data !== 16'h0003 || rs2_data !== 16'h0) begin
            failures++;
            $display("FAIL bitrev_exec got en=%b rs1=%h rs2=%h want en=0010 rs1=0003 rs2=0000",
                     {Radd_en, Rsub_en, bitrev_en, mul_en}, rs1_data, rs2_data);
        end
        wait_wb(n);
        checks++;
        if (wb_addr !== 3'd7 || wb_data !== 16'hC000) begin
            failures++;
            $display("FAIL bitrev_wb got addr=%0d data=%h want addr=7 data=c000", wb_addr, wb_data);
        end
    endtask

    task automatic test_illegal;
        logic [15:0] v;
        logic        seen_wb;
        send(16'hF650);                 // opcode F, rd=3 ; now in DECODE
        seen_wb = wb_valid;
        checks++;
        if (illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL illegal_early got=%b want=0", illegal_op);
        end
        @(negedge clk);
        seen_wb |= wb_valid;
        checks++;
        if (illegal_op !== 1'b1 || instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL illegal_pulse got ill=%b ready=%b want ill=1 ready=1", illegal_op, instr_ready);
        end
        @(negedge clk);
        seen_wb |= wb_valid;
        checks++;
        if (illegal_op !== 1'b0 || seen_wb !== 1'b0) begin
            failures++;
            $display("FAIL illegal_after got ill=%b wb_seen=%b want ill=0 wb_seen=0", illegal_op, seen_wb);
        end
        rd_dbg(3'd3, v);
        checks++;
        if (v !== 16'h0008) begin
            failures++;
            $display("FAIL illegal_regfile got r3=%h want=0008", v);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] rdy_pat, wb_pat, v;
        // ALU op held valid: accepts every 4th cycle
        rdy_pat = '0; wb_pat = '0;
        instr_valid = 1'b1;
        instr_data  = 16'h1C50;         // ADD r6,r1,r2 = 0x1FF+3
        for (int i = 0; i < 16; i++) begin
            rdy_pat[i] = instr_ready;
            wb_pat[i]  = wb_valid;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checks++;
        if (rdy_pat !== 16'h1111 || wb_pat !== 16'h1110) begin
            failures++;
            $display("FAIL b2b_alu got rdy=%h wb=%h want rdy=1111 wb=1110", rdy_pat, wb_pat);
        end
        repeat (5) @(negedge clk);
        rd_dbg(3'd6, v);
        checks++;
        if (v !== 16'h0202) begin
            failures++;
            $display("FAIL b2b_alu_data got=%h want=0202", v);
        end
        // LDI held valid: three-cycle cadence
        rdy_pat = '0; wb_pat = '0;
        instr_valid = 1'b1;
        instr_data  = 16'h5C11;         // LDI r6,0x11
        for (int i = 0; i < 16; i++) begin
            rdy_pat[i] = instr_ready;
            wb_pat[i]  = wb_valid;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checks++;
        if (rdy_pat !== 16'h9249 || wb_pat !== 16'h9248) begin
            failures++;
            $display("FAIL b2b_ldi got rdy=%h wb=%h want rdy=9249 wb=9248", rdy_pat, wb_pat);
        end
        repeat (5) @(negedge clk);
        rd_dbg(3'd6, v);
        checks++;
        if (v !== 16'h0011) begin
            failures++;
            $display("FAIL b2b_ldi_data got=%h want=0011", v);
        end
    endtask

    task automatic test_reset_mid_exec;
        int n;
        logic [15:0] v, any;
        send(16'h5205);                 // LDI r1,5
        wait_wb(n);
        send(16'h1648);                 // ADD r3,r1,r1
        @(negedge clk);                 // EXEC
        checks++;
        if (Radd_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_exec got add=%b want=1", Radd_en);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({Radd_en, Rsub_en, bitrev_en, mul_en} !== 4'b0 || rs1_data !== 16'h0 || rs2_data !== 16'h0 ||
            wb_data !== 16'h0 || wb_addr !== 3'h0) begin
            failures++;
            $display("FAIL rst_async got en=%b rs1=%h rs2=%h wbd=%h wba=%0d want all 0",
                     {Radd_en, Rsub_en, bitrev_en, mul_en}, rs1_data, rs2_data, wb_data, wb_addr);
        end
        any = 16'h0;
        for (int a = 0; a < 8; a++) begin
            rd_dbg(3'(a), v);
            any |= v;
        end
        checks++;
        if (any !== 16'h0) begin
            failures++;
            $display("FAIL rst_regfile got or=%h want 0000", any);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_release got ready=%b wbv=%b want ready=1 wbv=0", instr_ready, wb_valid);
        end
        send(16'h5407);                 // LDI r2,7 after reset
        wait_wb(n);
        checks++;
        if (n !== 2 || wb_addr !== 3'd2 || wb_data !== 16'h0007) begin
            failures++;
            $display("FAIL rst_resume got lat=%0d addr=%0d data=%h want lat=2 addr=2 data=0007", n, wb_addr, wb_data);
        end
    endtask

    initial begin
        rst         = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 16'h0;
        dbg_addr    = 3'd0;
        test_reset();
        test_ldi_add();
        test_sub();
        test_mul();
        test_bitrev();
        test_illegal();
        test_back_to_back();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
